// File: rtl/softmax_grad_rows.sv
// softmax_grad_rows
// Row-wise softmax backward: dX = Y * (dY - rowsum(Y * dY)), one row at a
// time, using one multiplier shared between the row-sum pass (ACC) and the
// per-element apply pass (APPLY).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  handshake for capturing y and dy (ready only in IDLE)
//   y                  packed Y, unsigned Q0.Y_WIDTH, element (i,j) at
//                      [Y_WIDTH*(i*COL_IN+j) +: Y_WIDTH]
//   dy                 packed dY, signed, same ordering
//   out_valid/out_ready handshake for delivering dx (valid only in DONE)
//   dx                 packed dX, signed, saturated to OUTPUT_DATA_WIDTH
//   busy               high whenever the block is not IDLE
module softmax_grad_rows #(
    parameter int Y_WIDTH           = 16,
    parameter int GRAD_WIDTH        = 16,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ROW_IN            = 8,
    parameter int COL_IN            = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [Y_WIDTH*ROW_IN*COL_IN-1:0]           y,
    input  logic [GRAD_WIDTH*ROW_IN*COL_IN-1:0]        dy,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [OUTPUT_DATA_WIDTH*ROW_IN*COL_IN-1:0] dx,
    output logic                                    busy
);

    localparam int RW = (ROW_IN > 1) ? $clog2(ROW_IN) : 1;
    localparam int CW = $clog2(COL_IN);
    localparam int AW = Y_WIDTH + GRAD_WIDTH + $clog2(COL_IN) + 1;
    localparam int DW = GRAD_WIDTH + 2;
    localparam int PW = Y_WIDTH + 1 + DW;
    localparam int QW = PW - Y_WIDTH;
    localparam int OW = OUTPUT_DATA_WIDTH;
    localparam int EW = (QW > OW) ? QW : OW;
    localparam logic signed [EW-1:0] OUT_MAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] OUT_MIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, APPLY, DONE} state_t;

    state_t state, state_next;

    logic [Y_WIDTH*ROW_IN*COL_IN-1:0]    y_reg;
    logic [GRAD_WIDTH*ROW_IN*COL_IN-1:0] dy_reg;
    logic [OW*ROW_IN*COL_IN-1:0]         dx_reg;
    logic [RW-1:0]                       r;
    logic [CW-1:0]                       c;
    logic signed [AW-1:0]                acc;
    logic signed [DW-1:0]                s_reg;

    logic                                last_col, last_row;
    int unsigned                         idx;
    logic [Y_WIDTH-1:0]                  y_e;
    logic [GRAD_WIDTH-1:0]               dy_e;
    logic signed [DW-1:0]                dy_x, diff, mul_b;
    logic signed [Y_WIDTH:0]             mul_a;
    logic signed [PW-1:0]                mul_p;
    logic signed [AW-1:0]                acc_next;
    logic signed [QW-1:0]                p_q;
    logic signed [EW-1:0]                p_e;
    logic [OW-1:0]                       dx_e;

    assign last_col = (c == CW'(COL_IN - 1));
    assign last_row = (r == RW'(ROW_IN - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dx        = dx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = ACC;
            ACC:     if (last_col)  state_next = APPLY;
            APPLY:   if (last_col)  state_next = last_row ? DONE : ACC;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared multiplier: ACC feeds y*dy, APPLY feeds y*(dy - s).
    // y is widened with a zero MSB so the product is a plain signed multiply.
    always_comb begin
        idx      = 32'(r) * 32'(COL_IN) + 32'(c);
        y_e      = y_reg[Y_WIDTH*idx +: Y_WIDTH];
        dy_e     = dy_reg[GRAD_WIDTH*idx +: GRAD_WIDTH];
        dy_x     = {{2{dy_e[GRAD_WIDTH-1]}}, dy_e};
        diff     = dy_x - s_reg;
        mul_a    = {1'b0, y_e};
        mul_b    = (state == APPLY) ? diff : dy_x;
        mul_p    = PW'(mul_a) * PW'(mul_b);
        acc_next = acc + AW'(mul_p);
        // Dropping the low Y_WIDTH bits of a two's complement value is a floor.
        p_q      = mul_p[PW-1:Y_WIDTH];
        p_e      = EW'(p_q);
        if (p_e > OUT_MAX)      dx_e = OUT_MAX[OW-1:0];
        else if (p_e < OUT_MIN) dx_e = OUT_MIN[OW-1:0];
        else                    dx_e = p_e[OW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg  <= '0;
            dy_reg <= '0;
            dx_reg <= '0;
            r      <= '0;
            c      <= '0;
            acc    <= '0;
            s_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_reg  <= y;
                        dy_reg <= dy;
                        r      <= '0;
                        c      <= '0;
                        acc    <= '0;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (last_col) begin
                        c     <= '0;
                        // acc_next >>> Y_WIDTH, kept only to the width d is formed at
                        s_reg <= acc_next[Y_WIDTH +: DW];
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                APPLY: begin
                    dx_reg[OW*idx +: OW] <= dx_e;
                    if (last_col) begin
                        c   <= '0;
                        acc <= '0;
                        if (!last_row) r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_grad_rows.sv
`timescale 1ns/1ps
module tb_softmax_grad_rows;

    localparam int YW = 16;
    localparam int GW = 16;
    localparam int R  = 8;
    localparam int C  = 8;
    localparam int N  = R * C;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic             in_ready, out_valid, busy;
    logic             in_ready8, out_valid8, busy8;
    logic [YW*N-1:0]  y = '0;
    logic [GW*N-1:0]  dy = '0;
    logic [16*N-1:0]  dx16;
    logic [8*N-1:0]   dx8;

    int ya[R][C];
    int dya[R][C];
    int exp16[R][C];
    int exp8[R][C];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    softmax_grad_rows #(
        .Y_WIDTH(YW), .GRAD_WIDTH(GW), .OUTPUT_DATA_WIDTH(16), .ROW_IN(R), .COL_IN(C)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .dy(dy), .out_valid(out_valid), .out_ready(out_ready),
        .dx(dx16), .busy(busy)
    );

    softmax_grad_rows #(
        .Y_WIDTH(YW), .GRAD_WIDTH(GW), .OUTPUT_DATA_WIDTH(8), .ROW_IN(R), .COL_IN(C)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .y(y), .dy(dy), .out_valid(out_valid8), .out_ready(out_ready),
        .dx(dx8), .busy(busy8)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    // Reference: s = floor(sum(y*dy) / 2^YW); dx = sat(floor(y*(dy-s) / 2^YW)).
    task automatic model();
        longint sum, s, p;
        for (int i = 0; i < R; i++) begin
            sum = 0;
            for (int j = 0; j < C; j++) sum += longint'(ya[i][j]) * longint'(dya[i][j]);
            s = sum >>> YW;
            for (int j = 0; j < C; j++) begin
                p = (longint'(ya[i][j]) * (longint'(dya[i][j]) - s)) >>> YW;
                exp16[i][j] = sat(p, 16);
                exp8[i][j]  = sat(p, 8);
            end
        end
    endtask

    task automatic pack();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                y[YW*(i*C+j) +: YW]  = ya[i][j][YW-1:0];
                dy[GW*(i*C+j) +: GW] = dya[i][j][GW-1:0];
            end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ya[i][j]  = 0;
                dya[i][j] = 0;
            end
    endtask

    task automatic set_two_hot();
        clear_vec();
        ya[0][0] = 32'h8000; ya[0][1] = 32'h8000;
        dya[0][0] = 1024;    dya[0][1] = 0;
    endtask

    task automatic set_mixed(input int sign);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ya[i][j]  = (j + 1) * 1792;
                dya[i][j] = sign * ((i + 1) * 100 - j * 173);
            end
    endtask

    function automatic int el16(input int i, input int j);
        return int'($signed(dx16[16*(i*C+j) +: 16]));
    endfunction

    function automatic int el8(input int i, input int j);
        return int'($signed(dx8[8*(i*C+j) +: 8]));
    endfunction

    // Whenever a result is presented, it must match the reference in full.
    always @(negedge clk) begin
        int bi, bj;
        if (rst_n && out_valid) begin
            bi = -1; bj = -1;
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    if (bi < 0 && el16(i, j) != exp16[i][j]) begin bi = i; bj = j; end
            checks++;
            if (bi >= 0) begin
                errors++;
                $display("FAIL dx16(%0d,%0d): got %0d, expected %0d", bi, bj, el16(bi, bj), exp16[bi][bj]);
            end
            checks++;
            if (in_ready) begin
                errors++;
                $display("FAIL in_ready_while_done: got 1, expected 0");
            end
        end
        if (rst_n && out_valid8) begin
            bi = -1; bj = -1;
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    if (bi < 0 && el8(i, j) != exp8[i][j]) begin bi = i; bj = j; end
            checks++;
            if (bi >= 0) begin
                errors++;
                $display("FAIL dx8(%0d,%0d): got %0d, expected %0d", bi, bj, el8(bi, bj), exp8[bi][bj]);
            end
        end
    end

    // Present the current vectors and return after the accepting edge (edge 0).
    task automatic accept(input int hold, output int waited);
        model();
        pack();
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        waited    = 0;
        while (!in_ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        y  = ~y;
        dy = ~dy;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic finish_txn(input int hold);
        int k;
        k = 0;
        while (!out_valid && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, 2 * R * C);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
        check("handoff_busy", busy, 0);
        check("dx_kept", el16(R-1, C-1), exp16[R-1][C-1]);
    endtask

    initial begin
        int w;
        #200_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dx16_ones", $countones(dx16), 0);
        check("rst_dx8_ones", $countones(dx8), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference against hand-derived values.
        set_two_hot();
        model();
        check("model_two_hot_00", exp16[0][0], 256);
        check("model_two_hot_01", exp16[0][1], -256);
        check("model_sat_00", exp8[0][0], 127);
        check("model_sat_01", exp8[0][1], -128);
        clear_vec();
        ya[0][0] = 32'hFFFF; dya[0][0] = 1000;
        model();
        check("model_floor_00", exp16[0][0], 0);

        // Uniform rows: s equals dy, so every element cancels.
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ya[i][j] = 32'h2000; dya[i][j] = 300;
            end
        accept(0, w);
        finish_txn(0);
        check("uniform_dx_ones", $countones(dx16), 0);

        set_two_hot();
        accept(0, w);
        finish_txn(0);
        check("two_hot_00", el16(0, 0), 256);
        check("two_hot_01", el16(0, 1), -256);
        check("sat_00", el8(0, 0), 127);
        check("sat_01", el8(0, 1), -128);
        check("two_hot_other", el16(1, 0), 0);

        clear_vec();
        ya[0][0] = 32'hFFFF; dya[0][0] = 1000;
        accept(0, w);
        finish_txn(0);
        check("floor_00", el16(0, 0), 0);

        // Backpressure, then the earliest possible next accept.
        set_mixed(1);
        accept(20, w);
        finish_txn(20);
        set_two_hot();
        accept(0, w);
        check("b2b_accept_wait", w, 0);
        finish_txn(0);
        check("b2b_two_hot_00", el16(0, 0), 256);

        // Reset in the middle of a transaction.
        set_mixed(1);
        accept(0, w);
        repeat (40) @(posedge clk);
        #1;
        check("pre_rst_partial", ($countones(dx16) != 0) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_dx16_ones", $countones(dx16), 0);
        check("mid_rst_dx8_ones", $countones(dx8), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_mixed(-1);
        accept(0, w);
        finish_txn(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
